// File: rtl/tdc_enc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_enc_pkg
// Shared constants, the per-segment result record and small combinational
// helpers for the TDC thermometer encoder.
//
// Optional feature macro: TDC_BUBBLE_FILTER_EN. When it is defined, a 5-tap
// majority filter stage is added and LATENCY becomes 5.
//
// The segment result fields are sized from DEF_SEG_WIDTH. A SEG_WIDTH override
// on the top must therefore satisfy SEG_WIDTH <= 2**LOCAL_W.
// -----------------------------------------------------------------------------
package tdc_enc_pkg;

  localparam int DEF_NUM_TAPS  = 768;
  localparam int DEF_SEG_WIDTH = 48;
  localparam int DEF_OUT_WIDTH = 16;

  localparam int NUM_SEG   = DEF_NUM_TAPS / DEF_SEG_WIDTH;
  localparam int LOCAL_W   = $clog2(DEF_SEG_WIDTH);
  // One spare bit: a slice can hold SEG_WIDTH/4+1 edges, which fits easily.
  localparam int SEG_CNT_W = LOCAL_W + 1;

  localparam logic MODE_LAST  = 1'b0;
  localparam logic MODE_FIRST = 1'b1;

`ifdef TDC_BUBBLE_FILTER_EN
  localparam int LATENCY = 5;
`else
  localparam int LATENCY = 4;
`endif

  typedef struct packed {
    logic                 any;
    logic [LOCAL_W-1:0]   lo_idx;
    logic [LOCAL_W-1:0]   hi_idx;
    logic [SEG_CNT_W-1:0] cnt;
  } seg_result_t;

  // Clamp a tap index into the line, so the ends replicate the end taps.
  function automatic int clamp_tap(input int idx, input int num_taps);
    return (idx < 0) ? 0 : ((idx > num_taps - 1) ? num_taps - 1 : idx);
  endfunction

  // Majority vote of five bits: at least three ones.
  function automatic logic majority5(input logic [4:0] w);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 5; i++) begin
      ones = ones + {2'b00, w[i]};
    end
    return (ones >= 3'd3);
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder_seg.sv
// -----------------------------------------------------------------------------
// tdc_seg_encoder
// Encodes one SEG_WIDTH slice of the edge vector into a registered record:
// the lowest and highest local edge index, an any flag and a local popcount.
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_edges edge vector slice, bit 0 = lowest tap of the slice
//   o_res   registered segment result
// -----------------------------------------------------------------------------
module tdc_seg_encoder
  import tdc_enc_pkg::*;
#(
  parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SEG_WIDTH-1:0] i_edges,
  output seg_result_t          o_res
);

  logic [LOCAL_W-1:0]   lo_s;
  logic [LOCAL_W-1:0]   hi_s;
  logic [SEG_CNT_W-1:0] cnt_s;
  logic                 any_s;

  // Priority scans: ascending scan leaves the highest set index, descending the lowest.
  always_comb begin
    lo_s  = '0;
    hi_s  = '0;
    cnt_s = '0;
    any_s = |i_edges;
    for (int k = 0; k < SEG_WIDTH; k++) begin
      hi_s  = i_edges[k] ? LOCAL_W'(k) : hi_s;
      cnt_s = cnt_s + SEG_CNT_W'(i_edges[k]);
    end
    for (int k = SEG_WIDTH - 1; k >= 0; k--) begin
      lo_s = i_edges[k] ? LOCAL_W'(k) : lo_s;
    end
  end

  // Segment result register (pipeline stage S3).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res <= '0;
    end else begin
      o_res.any    <= any_s;
      o_res.lo_idx <= lo_s;
      o_res.hi_idx <= hi_s;
      o_res.cnt    <= cnt_s;
    end
  end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// -----------------------------------------------------------------------------
// tdc_thermo_encoder
// Converts one captured delay-line thermometer snapshot into the tap index of
// the first or last rising (0->1) edge, plus the total edge count. The design is
// fully pipelined at one sample per clock, with 4 cycles of latency (5 cycles
// when TDC_BUBBLE_FILTER_EN is defined).
//
// Optional feature macro: TDC_BUBBLE_FILTER_EN. It inserts a 5-tap majority
// filter stage between S1 and S2.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset; drops all in-flight samples
//   i_valid     i_din/i_mode carry a new sample
//   i_mode      0 = highest-index edge, 1 = lowest-index edge
//   i_din       thermometer snapshot, tap 0 = start of line
//   o_valid     one-cycle pulse per accepted sample
//   o_pos       selected edge tap index (0 when no edge)
//   o_edge_cnt  number of edges found
//   o_no_edge   no edge found
//   o_multi     more than one edge found
// Data outputs hold their last value while o_valid is low.
// -----------------------------------------------------------------------------
module tdc_thermo_encoder
  import tdc_enc_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int SEG_WIDTH = DEF_SEG_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_mode,
  input  logic [NUM_TAPS-1:0]  i_din,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_pos,
  output logic [OUT_WIDTH-1:0] o_edge_cnt,
  output logic                 o_no_edge,
  output logic                 o_multi
);

  localparam int N_SEG = NUM_TAPS / SEG_WIDTH;

  // ---------------------------------------------------------------- S1
  logic                s1_valid_r;
  logic                s1_mode_r;
  logic [NUM_TAPS-1:0] s1_din_r;

  // Capture the snapshot and its mode only when a sample is offered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= i_valid;
      if (i_valid) begin
        s1_din_r  <= i_din;
        s1_mode_r <= i_mode;
      end
    end
  end

  // ------------------------------------------------- optional filter F
  logic [NUM_TAPS-1:0] edge_src_s;
  logic                edge_src_valid_s;
  logic                edge_src_mode_s;

`ifdef TDC_BUBBLE_FILTER_EN
  logic [NUM_TAPS-1:0] flt_s;
  logic [NUM_TAPS-1:0] f_din_r;
  logic                f_valid_r;
  logic                f_mode_r;

  // 5-tap majority vote; off-line neighbours replicate the nearest end tap.
  always_comb begin
    flt_s = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      flt_s[k] = majority5({s1_din_r[clamp_tap(k + 2, NUM_TAPS)],
                            s1_din_r[clamp_tap(k + 1, NUM_TAPS)],
                            s1_din_r[k],
                            s1_din_r[clamp_tap(k - 1, NUM_TAPS)],
                            s1_din_r[clamp_tap(k - 2, NUM_TAPS)]});
    end
  end

  // Filter stage register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f_valid_r <= 1'b0;
    end else begin
      f_valid_r <= s1_valid_r;
      f_din_r   <= flt_s;
      f_mode_r  <= s1_mode_r;
    end
  end

  assign edge_src_s       = f_din_r;
  assign edge_src_valid_s = f_valid_r;
  assign edge_src_mode_s  = f_mode_r;
`else
  assign edge_src_s       = s1_din_r;
  assign edge_src_valid_s = s1_valid_r;
  assign edge_src_mode_s  = s1_mode_r;
`endif

  // ---------------------------------------------------------------- S2
  logic [NUM_TAPS-1:0] edge_vec_s;
  logic [NUM_TAPS-1:0] s2_edge_r;
  logic                s2_valid_r;
  logic                s2_mode_r;

  // Rising edge = two zeros then two ones. Taps 0 and 1 use shortened windows
  // anchored at the line start, and the last tap can never qualify.
  always_comb begin
    edge_vec_s    = '0;
    edge_vec_s[0] = ~edge_src_s[0] &  edge_src_s[1] & edge_src_s[2] & edge_src_s[3];
    edge_vec_s[1] = ~edge_src_s[0] & ~edge_src_s[1] & edge_src_s[2] & edge_src_s[3];
    for (int k = 2; k <= NUM_TAPS - 2; k++) begin
      edge_vec_s[k] = ~edge_src_s[k-2] & ~edge_src_s[k-1] & edge_src_s[k] & edge_src_s[k+1];
    end
    edge_vec_s[NUM_TAPS-1] = 1'b0;
  end

  // Edge vector register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= edge_src_valid_s;
      s2_edge_r  <= edge_vec_s;
      s2_mode_r  <= edge_src_mode_s;
    end
  end

  // ---------------------------------------------------------------- S3
  seg_result_t seg_res_s [N_SEG];
  logic        s3_valid_r;
  logic        s3_mode_r;

  for (genvar g = 0; g < N_SEG; g++) begin : g_seg
    tdc_seg_encoder #(
      .SEG_WIDTH (SEG_WIDTH)
    ) u_seg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_edges (s2_edge_r[g*SEG_WIDTH +: SEG_WIDTH]),
      .o_res   (seg_res_s[g])
    );
  end

  // Valid and mode run alongside the segment registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3_valid_r <= 1'b0;
    end else begin
      s3_valid_r <= s2_valid_r;
      s3_mode_r  <= s2_mode_r;
    end
  end

  // ---------------------------------------------------------------- S4
  logic [OUT_WIDTH-1:0] sum_s;
  logic [OUT_WIDTH-1:0] last_pos_s;
  logic [OUT_WIDTH-1:0] first_pos_s;
  logic [OUT_WIDTH-1:0] sel_pos_s;
  logic                 any_s;

  // Cross-segment reduction. Ascending scan keeps the highest segment with an
  // edge, descending keeps the lowest. Both stay 0 when no segment has an edge.
  always_comb begin
    sum_s       = '0;
    last_pos_s  = '0;
    first_pos_s = '0;
    any_s       = 1'b0;
    for (int s = 0; s < N_SEG; s++) begin
      sum_s      = sum_s + OUT_WIDTH'(seg_res_s[s].cnt);
      any_s      = any_s | seg_res_s[s].any;
      last_pos_s = seg_res_s[s].any
                 ? OUT_WIDTH'(s * SEG_WIDTH) + OUT_WIDTH'(seg_res_s[s].hi_idx)
                 : last_pos_s;
    end
    for (int s = N_SEG - 1; s >= 0; s--) begin
      first_pos_s = seg_res_s[s].any
                  ? OUT_WIDTH'(s * SEG_WIDTH) + OUT_WIDTH'(seg_res_s[s].lo_idx)
                  : first_pos_s;
    end
    case (s3_mode_r)
      MODE_FIRST: sel_pos_s = first_pos_s;
      MODE_LAST:  sel_pos_s = last_pos_s;
      default:    sel_pos_s = last_pos_s;
    endcase
  end

  // Output register; data holds while no sample completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_pos      <= '0;
      o_edge_cnt <= '0;
      o_no_edge  <= 1'b0;
      o_multi    <= 1'b0;
    end else begin
      o_valid <= s3_valid_r;
      if (s3_valid_r) begin
        o_pos      <= sel_pos_s;
        o_edge_cnt <= sum_s;
        o_no_edge  <= ~any_s;
        o_multi    <= (sum_s > OUT_WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// -----------------------------------------------------------------------------
// tb_tdc_thermo_encoder
// Self-checking bench for tdc_thermo_encoder. The expected results come from a
// tap-by-tap reference model that applies the edge rules directly. The model
// also applies the majority filter when TDC_BUBBLE_FILTER_EN is defined.
// -----------------------------------------------------------------------------
module tb_tdc_thermo_encoder;

  localparam int NT = 768;
`ifdef TDC_BUBBLE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic          clk;
  logic          i_rst;
  logic          i_valid;
  logic          i_mode;
  logic [NT-1:0] i_din;
  logic          o_valid;
  logic [15:0]   o_pos;
  logic [15:0]   o_edge_cnt;
  logic          o_no_edge;
  logic          o_multi;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NT-1:0] st_din  [16];
  logic          st_mode [16];
  int            cap_pos   [16];
  int            cap_cnt   [16];
  int            cap_lat   [16];
  logic          cap_no    [16];
  logic          cap_multi [16];
  int            cap_n;

  tdc_thermo_encoder dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_mode     (i_mode),
    .i_din      (i_din),
    .o_valid    (o_valid),
    .o_pos      (o_pos),
    .o_edge_cnt (o_edge_cnt),
    .o_no_edge  (o_no_edge),
    .o_multi    (o_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ones from tap k to the end of the line.
  function automatic logic [NT-1:0] thermo_from(input int k);
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = (i >= k);
    return v;
  endfunction

  function automatic logic [NT-1:0] rand_bits();
    logic [NT-1:0] v;
    for (int i = 0; i < NT / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Alternating runs of random length, so the pattern has a few real edges and some bubbles.
  function automatic logic [NT-1:0] rand_runs();
    logic [NT-1:0] v;
    logic lvl;
    int k, run;
    v = '0;
    lvl = 1'($urandom_range(1, 0));
    k = 0;
    while (k < NT) begin
      run = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(120, 4);
      for (int j = 0; j < run; j++) begin
        if (k < NT) v[k] = lvl;
        k++;
      end
      lvl = ~lvl;
    end
    return v;
  endfunction

  // Reference: optional majority filter, then the edge rules tap by tap.
  // The global min/max edge index gives the first/last edge position.
  function automatic void ref_model(input logic [NT-1:0] din, input logic mode,
                                    output int pos, output int cnt);
    logic [NT-1:0] d;
    int lo, hi, ones, idx;
    bit e;
    d = din;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int k = 0; k < NT; k++) begin
      ones = 0;
      for (int j = -2; j <= 2; j++) begin
        idx = k + j;
        if (idx < 0) idx = 0;
        if (idx > NT - 1) idx = NT - 1;
        ones += int'(din[idx]);
      end
      d[k] = (ones >= 3);
    end
`endif
    cnt = 0; lo = -1; hi = -1;
    for (int k = 0; k < NT; k++) begin
      if (k == 0)            e = !d[0] && d[1] && d[2] && d[3];
      else if (k == 1)       e = !d[0] && !d[1] && d[2] && d[3];
      else if (k == NT - 1)  e = 1'b0;
      else                   e = !d[k-2] && !d[k-1] && d[k] && d[k+1];
      if (e) begin
        cnt++;
        if (lo < 0) lo = k;
        hi = k;
      end
    end
    pos = (cnt == 0) ? 0 : (mode ? lo : hi);
  endfunction

  // Drive st_din/st_mode[0..n-1] on consecutive cycles and capture every o_valid pulse.
  task automatic run_batch(input int n);
    cap_n = 0;
    for (int cyc = 0; cyc < n + LAT + 4; cyc++) begin
      @(negedge clk);
      if (o_valid) begin
        if (cap_n < 16) begin
          cap_pos[cap_n]   = int'(o_pos);
          cap_cnt[cap_n]   = int'(o_edge_cnt);
          cap_no[cap_n]    = o_no_edge;
          cap_multi[cap_n] = o_multi;
          cap_lat[cap_n]   = cyc - cap_n;
        end
        cap_n++;
      end
      if (cyc < n) begin
        i_valid = 1'b1;
        i_din   = st_din[cyc];
        i_mode  = st_mode[cyc];
      end else begin
        i_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_din = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    n_tests++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_pos !== 16'd0)      begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", o_pos); end
    n_tests++; if (o_edge_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", o_edge_cnt); end
    n_tests++; if (o_no_edge !== 1'b0)   begin n_fail++; $display("FAIL reset_no_edge: got %b expected 0", o_no_edge); end
    n_tests++; if (o_multi !== 1'b0)     begin n_fail++; $display("FAIL reset_multi: got %b expected 0", o_multi); end
    // Three samples in flight, then a one-cycle reset: none may emerge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_din = thermo_from(100 + i); i_mode = 1'b0;
    end
    @(negedge clk);
    i_valid = 1'b0; i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    pulses = (o_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL reset_flush: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_single_edge();
    st_din[0] = thermo_from(100); st_mode[0] = 1'b0;
    run_batch(1);
    n_tests++; if (cap_n != 1)       begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", cap_n); end
    n_tests++; if (cap_lat[0] != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cap_lat[0], LAT); end
    n_tests++; if (cap_pos[0] != 100) begin n_fail++; $display("FAIL single_pos: got %0d expected 100", cap_pos[0]); end
    n_tests++; if (cap_cnt[0] != 1)   begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cap_cnt[0]); end
    n_tests++; if (cap_no[0] !== 1'b0 || cap_multi[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_flags: got no_edge=%b multi=%b expected 0 0", cap_no[0], cap_multi[0]);
    end
  endtask

  task automatic test_two_edges();
    logic [NT-1:0] v;
    v = thermo_from(300);
    for (int i = 100; i < 200; i++) v[i] = 1'b1;
    st_din[0] = v; st_mode[0] = 1'b0;
    st_din[1] = v; st_mode[1] = 1'b1;
    run_batch(2);
    n_tests++; if (cap_n != 2)        begin n_fail++; $display("FAIL two_pulses: got %0d expected 2", cap_n); end
    n_tests++; if (cap_pos[0] != 300) begin n_fail++; $display("FAIL two_pos_last: got %0d expected 300", cap_pos[0]); end
    n_tests++; if (cap_pos[1] != 100) begin n_fail++; $display("FAIL two_pos_first: got %0d expected 100", cap_pos[1]); end
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (cap_cnt[i] != 2 || cap_multi[i] !== 1'b1 || cap_no[i] !== 1'b0) begin
        n_fail++; $display("FAIL two_cnt%0d: got cnt=%0d multi=%b no_edge=%b expected 2 1 0", i, cap_cnt[i], cap_multi[i], cap_no[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int exp_pos [5] = '{0, 0, 1, 2, 0};
    int exp_cnt [5] = '{0, 1, 2, 2, 0};
    st_din[0] = '0;             st_mode[0] = 1'b0;
    st_din[1] = thermo_from(1); st_mode[1] = 1'b1;
    st_din[2] = thermo_from(2); st_mode[2] = 1'b1;
    st_din[3] = thermo_from(2); st_mode[3] = 1'b0;
    st_din[4] = '1;             st_mode[4] = 1'b0;
    run_batch(5);
    n_tests++; if (cap_n != 5) begin n_fail++; $display("FAIL bound_pulses: got %0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (cap_pos[i] != exp_pos[i] || cap_cnt[i] != exp_cnt[i] ||
                     cap_no[i] !== (exp_cnt[i] == 0) || cap_multi[i] !== (exp_cnt[i] > 1)) begin
        n_fail++; $display("FAIL bound_case%0d: got pos=%0d cnt=%0d no_edge=%b multi=%b expected pos=%0d cnt=%0d",
                           i, cap_pos[i], cap_cnt[i], cap_no[i], cap_multi[i], exp_pos[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int taps [4] = '{47, 48, 95, 765};
    for (int i = 0; i < 4; i++) begin
      st_din[i] = thermo_from(taps[i]); st_mode[i] = 1'(i % 2);
    end
    run_batch(4);
    n_tests++; if (cap_n != 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (cap_pos[i] != taps[i] || cap_cnt[i] != 1 || cap_lat[i] != LAT) begin
        n_fail++; $display("FAIL b2b_sample%0d: got pos=%0d cnt=%0d lat=%0d expected pos=%0d cnt=1 lat=%0d",
                           i, cap_pos[i], cap_cnt[i], cap_lat[i], taps[i], LAT);
      end
    end
  endtask

  task automatic test_bubble();
    logic [NT-1:0] v;
    v = thermo_from(100);
    v[150] = 1'b0; v[151] = 1'b0;
    st_din[0] = v; st_mode[0] = 1'b0;
    st_din[1] = v; st_mode[1] = 1'b1;
    run_batch(2);
`ifdef TDC_BUBBLE_FILTER_EN
    n_tests++; if (cap_pos[0] != 100 || cap_cnt[0] != 1) begin
      n_fail++; $display("FAIL bubble_last: got pos=%0d cnt=%0d expected 100 1", cap_pos[0], cap_cnt[0]);
    end
`else
    n_tests++; if (cap_pos[0] != 152 || cap_cnt[0] != 2) begin
      n_fail++; $display("FAIL bubble_last: got pos=%0d cnt=%0d expected 152 2", cap_pos[0], cap_cnt[0]);
    end
`endif
    n_tests++; if (cap_pos[1] != 100) begin n_fail++; $display("FAIL bubble_first: got %0d expected 100", cap_pos[1]); end
    n_tests++; if (cap_lat[0] != LAT) begin n_fail++; $display("FAIL bubble_latency: got %0d expected %0d", cap_lat[0], LAT); end
  endtask

  task automatic test_random();
    int epos, ecnt;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 10; i++) begin
        st_din[i]  = ($urandom_range(3, 0) == 0) ? rand_bits() : rand_runs();
        st_mode[i] = 1'($urandom_range(1, 0));
      end
      run_batch(10);
      n_tests++; if (cap_n != 10) begin n_fail++; $display("FAIL rand_pulses b%0d: got %0d expected 10", b, cap_n); end
      for (int i = 0; i < 10; i++) begin
        ref_model(st_din[i], st_mode[i], epos, ecnt);
        n_tests++; if (cap_pos[i] != epos || cap_cnt[i] != ecnt || cap_lat[i] != LAT ||
                       cap_no[i] !== (ecnt == 0) || cap_multi[i] !== (ecnt > 1)) begin
          n_fail++; $display("FAIL rand_b%0d_s%0d: got pos=%0d cnt=%0d lat=%0d no_edge=%b multi=%b expected pos=%0d cnt=%0d lat=%0d",
                             b, i, cap_pos[i], cap_cnt[i], cap_lat[i], cap_no[i], cap_multi[i], epos, ecnt, LAT);
        end
      end
    end
  endtask

  // Garbage on i_din with i_valid low must leave the last result on the outputs.
  task automatic test_held_outputs();
    int epos, ecnt;
    ref_model(st_din[9], st_mode[9], epos, ecnt);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      i_valid = 1'b0; i_din = rand_bits(); i_mode = ~i_mode;
    end
    @(negedge clk);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL held_valid: got %b expected 0", o_valid); end
    n_tests++; if (int'(o_pos) != epos || int'(o_edge_cnt) != ecnt ||
                   o_no_edge !== (ecnt == 0) || o_multi !== (ecnt > 1)) begin
      n_fail++; $display("FAIL held_data: got pos=%0d cnt=%0d no_edge=%b multi=%b expected pos=%0d cnt=%0d",
                         o_pos, o_edge_cnt, o_no_edge, o_multi, epos, ecnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_two_edges();
    test_boundary();
    test_back_to_back();
    test_bubble();
    test_random();
    test_held_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_thermo_encoder.md
Name: tdc_thermo_encoder

Overview:
Parametrised successor to the single-line TDC edge encoder. It converts one captured delay-line thermometer snapshot into a tap position plus an edge count.
- Fully pipelined at one sample per clock, with a valid strobe in and out.
- First/last edge selectable per sample; multi-edge count always reported.
- Sits between the delay-line capture registers and the histogram/calibration logic.

Parameters:
NUM_TAPS, 768, number of delay-line taps; must be a multiple of SEG_WIDTH
SEG_WIDTH, 48, taps per segment (one carry/DSP cascade slice)
OUT_WIDTH, 16, width of o_pos and o_edge_cnt; must be >= clog2(NUM_TAPS)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  i_din holds a new snapshot this cycle
i_mode  in  1  0 = report highest-index edge, 1 = report lowest-index edge; sampled with i_valid
i_din  in  NUM_TAPS  raw thermometer snapshot, tap 0 = start of line
o_valid  out  1  outputs valid, single-cycle pulse per accepted sample
o_pos  out  OUT_WIDTH  selected edge tap index
o_edge_cnt  out  OUT_WIDTH  number of detected edges in the snapshot
o_no_edge  out  1  no edge detected (o_pos forced to 0)
o_multi  out  1  o_edge_cnt > 1

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: all outputs 0. All pipeline valid bits cleared on the cycle i_rst is sampled high. In-flight samples are discarded, never emitted.
- Edge rule, tap k with 2 <= k <= NUM_TAPS-2: edge[k] = ~d[k-2] & ~d[k-1] & d[k] & d[k+1].
- Edge rule, boundary taps:
  - edge[0] = ~d0 & d1 & d2 & d3
  - edge[1] = ~d0 & ~d1 & d2 & d3
  - edge[NUM_TAPS-1] = 0
- Only 0→1 transitions with increasing index are detected; 1→0 is ignored.
- Pipeline, latency exactly 4 cycles from i_valid to o_valid:
  - S1: register i_din and i_mode when i_valid.
  - S2: compute and register the edge vector.
  - S3: per segment, register the local lowest index, local highest index, any flag, and local popcount.
  - S4: reduce across segments and register outputs.
- Throughput: i_valid may be asserted every cycle; there is no backpressure. Each i_valid produces exactly one o_valid.
- Position: o_pos = seg*SEG_WIDTH + local index of the winning segment. The winner is the highest segment with any=1 in mode 0, the lowest in mode 1.
- Mode alignment: i_mode travels down the pipe with its own sample; changing mode between back-to-back samples must not affect the other sample.
- No edge: o_pos=0, o_edge_cnt=0, o_no_edge=1, o_multi=0.
- Count: o_edge_cnt is the sum of segment popcounts, zero-extended. It cannot overflow because the maximum is NUM_TAPS/4+1, below 2^OUT_WIDTH.
- Held outputs: when o_valid=0, data outputs hold their last values.

Optional Feature:
Macro TDC_BUBBLE_FILTER_EN.
- Defined:
  - An extra registered stage F between S1 and S2: d'[k] = majority of d[k-2..k+2] (at least 3 of 5 ones).
  - Out-of-range neighbours replicate the nearest in-range tap.
  - Removes bubbles up to 2 taps wide.
  - Latency becomes 5 cycles.
- Undefined: no filter stage; latency is 4 cycles.

Decomposition:
- Package tdc_enc_pkg:
  - MODE_LAST=1'b0, MODE_FIRST=1'b1
  - NUM_SEG = NUM_TAPS/SEG_WIDTH
  - LOCAL_W = clog2(SEG_WIDTH)
  - latency constant (4, or 5 with the filter)
  - segment result struct {any, lo_idx, hi_idx, cnt}
- Sub-module tdc_seg_encoder: one SEG_WIDTH slice of the edge vector in, registered segment result out. The top instantiates NUM_SEG of these and performs the S4 reduction.

Test Plan:
- Reset then idle: o_valid=0 and all outputs 0; assert i_rst for 1 cycle mid-stream with 3 samples in flight → no o_valid pulses for those samples.
- Thermometer ones from tap 100 upward, mode 0 → after 4 cycles o_valid=1, o_pos=100, o_edge_cnt=1, o_no_edge=0, o_multi=0.
- Ones at taps 100..199 and 300..767, mode 0 → o_pos=300, cnt=2, o_multi=1; same input with mode 1 → o_pos=100.
- Boundary cases: all zeros → o_no_edge=1, o_pos=0; din=...1110 → o_pos=0; din=...1100 → o_pos=1; all ones → o_no_edge=1.
- Back-to-back samples on 4 consecutive cycles with alternating modes and edges at 47, 48, 95, 767-2 → 4 consecutive o_valid pulses in order, each with its own mode's result. Taps 47 and 48 straddle a segment boundary.
- Bubble at taps 150..151 inside ones from 100: without TDC_BUBBLE_FILTER_EN → cnt=2, mode0 o_pos=152; with TDC_BUBBLE_FILTER_EN → cnt=1, o_pos=100, latency 5.
